// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, constants and id/slot helpers for the reorder buffer.
package reorder_buffer_pkg;
   localparam int ROB_SIZE = 16;
   localparam int ROB_ID_W = 5;
   localparam int DATA_W   = 32;
   localparam int REG_W    = 5;
   localparam int PC_W     = 32;
   localparam int PTR_W    = $clog2(ROB_SIZE);

   typedef logic [PTR_W-1:0]    ptr_t;
   typedef logic [ROB_ID_W-1:0] rob_id_t;

   localparam rob_id_t          ZERO_ROB = '0;
   localparam logic [REG_W-1:0] ZERO_REG = '0;
   localparam logic             TRUE     = 1'b1;
   localparam logic             FALSE    = 1'b0;

   // ids are slot index + 1 so that id 0 can mean "no producer"
   function automatic rob_id_t slot_to_id(input ptr_t slot);
      return rob_id_t'(slot) + rob_id_t'(1);
   endfunction

   function automatic ptr_t id_to_slot(input rob_id_t id);
      return ptr_t'(id - rob_id_t'(1));
   endfunction

   function automatic logic id_in_range(input rob_id_t id);
      return (id != ZERO_ROB) && (id <= rob_id_t'(ROB_SIZE));
   endfunction
endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates ids, captures CDB writebacks,
// retires one entry per cycle and flushes on a mispredicted branch at head.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc_valid,
   input  logic [REG_W-1:0]    alloc_rd,
   input  logic                alloc_is_store,
   input  logic [PC_W-1:0]     alloc_pc,
   output logic [ROB_ID_W-1:0] alloc_rob_id,
   output logic                full,
   input  logic [ROB_ID_W-1:0] query_id1,
   input  logic [ROB_ID_W-1:0] query_id2,
   output logic                query_ready1,
   output logic                query_ready2,
   output logic [DATA_W-1:0]   query_val1,
   output logic [DATA_W-1:0]   query_val2,
   input  logic                wb_valid,
   input  logic [ROB_ID_W-1:0] wb_rob_id,
   input  logic [DATA_W-1:0]   wb_value,
   input  logic                wb_mispredict,
   input  logic [PC_W-1:0]     wb_target_pc,
   output logic                commit_valid,
   output logic [REG_W-1:0]    commit_rd,
   output logic [DATA_W-1:0]   commit_value,
   output logic [ROB_ID_W-1:0] commit_rob_id,
   output logic                commit_store,
   output logic                rollback,
   output logic [PC_W-1:0]     rollback_pc
);

   logic              busy_q    [ROB_SIZE];
   logic              busy_d    [ROB_SIZE];
   logic              ready_q   [ROB_SIZE];
   logic              ready_d   [ROB_SIZE];
   logic              mispred_q [ROB_SIZE];
   logic              mispred_d [ROB_SIZE];
   logic              store_q   [ROB_SIZE];
   logic              store_d   [ROB_SIZE];
   logic [REG_W-1:0]  rd_q      [ROB_SIZE];
   logic [REG_W-1:0]  rd_d      [ROB_SIZE];
   logic [DATA_W-1:0] value_q   [ROB_SIZE];
   logic [DATA_W-1:0] value_d   [ROB_SIZE];
   logic [PC_W-1:0]   target_q  [ROB_SIZE];
   logic [PC_W-1:0]   target_d  [ROB_SIZE];
   logic [PC_W-1:0]   pc_q      [ROB_SIZE];
   logic [PC_W-1:0]   pc_d      [ROB_SIZE];

   ptr_t    head_q, head_d, tail_q, tail_d;
   rob_id_t count_q, count_d;

   logic              commit_valid_q, commit_valid_d;
   logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
   logic [DATA_W-1:0] commit_value_q, commit_value_d;
   rob_id_t           commit_rob_id_q, commit_rob_id_d;
   logic              commit_store_q, commit_store_d;
   logic              rollback_q, rollback_d;
   logic [PC_W-1:0]   rollback_pc_q, rollback_pc_d;

   logic commit_now, flush_now, alloc_ok, wb_hit;
   ptr_t wb_slot;

   always_comb begin
      busy_d    = busy_q;
      ready_d   = ready_q;
      mispred_d = mispred_q;
      store_d   = store_q;
      rd_d      = rd_q;
      value_d   = value_q;
      target_d  = target_q;
      pc_d      = pc_q;
      head_d    = head_q;
      tail_d    = tail_q;

      full       = (count_q == rob_id_t'(ROB_SIZE));
      commit_now = busy_q[head_q] && ready_q[head_q];
      flush_now  = commit_now && mispred_q[head_q];
      alloc_ok   = alloc_valid && !full && !flush_now;
      wb_slot    = id_to_slot(wb_rob_id);
      wb_hit     = wb_valid && id_in_range(wb_rob_id) && busy_q[wb_slot];

      if (alloc_ok) begin
         busy_d[tail_q]    = TRUE;
         ready_d[tail_q]   = FALSE;
         mispred_d[tail_q] = FALSE;
         store_d[tail_q]   = alloc_is_store;
         rd_d[tail_q]      = alloc_rd;
         pc_d[tail_q]      = alloc_pc;
         tail_d            = tail_q + ptr_t'(1);
      end

      if (wb_hit) begin
         ready_d[wb_slot]   = TRUE;
         value_d[wb_slot]   = wb_value;
         mispred_d[wb_slot] = wb_mispredict;
         target_d[wb_slot]  = wb_target_pc;
      end

      if (commit_now) begin
         busy_d[head_q]  = FALSE;
         ready_d[head_q] = FALSE;
         head_d          = head_q + ptr_t'(1);
      end

      count_d = count_q + rob_id_t'(alloc_ok) - rob_id_t'(commit_now);

      commit_valid_d  = commit_now;
      commit_rd_d     = commit_now ? rd_q[head_q] : ZERO_REG;
      commit_value_d  = commit_now ? value_q[head_q] : '0;
      commit_rob_id_d = commit_now ? slot_to_id(head_q) : ZERO_ROB;
      commit_store_d  = commit_now && store_q[head_q];
      rollback_d      = flush_now;
      rollback_pc_d   = flush_now ? target_q[head_q] : '0;

      // mispredict at head: the branch itself retires, everything younger dies
      if (flush_now) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            busy_d[i]    = FALSE;
            ready_d[i]   = FALSE;
            mispred_d[i] = FALSE;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q          <= '{default: '0};
         ready_q         <= '{default: '0};
         mispred_q       <= '{default: '0};
         store_q         <= '{default: '0};
         rd_q            <= '{default: '0};
         value_q         <= '{default: '0};
         target_q        <= '{default: '0};
         pc_q            <= '{default: '0};
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         commit_valid_q  <= 1'b0;
         commit_rd_q     <= '0;
         commit_value_q  <= '0;
         commit_rob_id_q <= '0;
         commit_store_q  <= 1'b0;
         rollback_q      <= 1'b0;
         rollback_pc_q   <= '0;
      end else begin
         busy_q          <= busy_d;
         ready_q         <= ready_d;
         mispred_q       <= mispred_d;
         store_q         <= store_d;
         rd_q            <= rd_d;
         value_q         <= value_d;
         target_q        <= target_d;
         pc_q            <= pc_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         commit_valid_q  <= commit_valid_d;
         commit_rd_q     <= commit_rd_d;
         commit_value_q  <= commit_value_d;
         commit_rob_id_q <= commit_rob_id_d;
         commit_store_q  <= commit_store_d;
         rollback_q      <= rollback_d;
         rollback_pc_q   <= rollback_pc_d;
      end
   end

   assign alloc_rob_id  = slot_to_id(tail_q);
   assign commit_valid  = commit_valid_q;
   assign commit_rd     = commit_rd_q;
   assign commit_value  = commit_value_q;
   assign commit_rob_id = commit_rob_id_q;
   assign commit_store  = commit_store_q;
   assign rollback      = rollback_q;
   assign rollback_pc   = rollback_pc_q;

   // operand lookup: stored result first, then same-cycle CDB bypass
   always_comb begin
      query_ready1 = FALSE;
      query_val1   = '0;
      if (query_id1 == ZERO_ROB) begin
         query_ready1 = TRUE;
      end else if (id_in_range(query_id1) && ready_q[id_to_slot(query_id1)]) begin
         query_ready1 = TRUE;
         query_val1   = value_q[id_to_slot(query_id1)];
      end else if (wb_valid && (wb_rob_id == query_id1)) begin
         query_ready1 = TRUE;
         query_val1   = wb_value;
      end
   end

   always_comb begin
      query_ready2 = FALSE;
      query_val2   = '0;
      if (query_id2 == ZERO_ROB) begin
         query_ready2 = TRUE;
      end else if (id_in_range(query_id2) && ready_q[id_to_slot(query_id2)]) begin
         query_ready2 = TRUE;
         query_val2   = value_q[id_to_slot(query_id2)];
      end else if (wb_valid && (wb_rob_id == query_id2)) begin
         query_ready2 = TRUE;
         query_val2   = wb_value;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        alloc_is_store;
   logic [31:0] alloc_pc;
   logic [4:0]  alloc_rob_id;
   logic        full;
   logic [4:0]  query_id1, query_id2;
   logic        query_ready1, query_ready2;
   logic [31:0] query_val1, query_val2;
   logic        wb_valid;
   logic [4:0]  wb_rob_id;
   logic [31:0] wb_value;
   logic        wb_mispredict;
   logic [31:0] wb_target_pc;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [4:0]  commit_rob_id;
   logic        commit_store;
   logic        rollback;
   logic [31:0] rollback_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_store(alloc_is_store),
      .alloc_pc(alloc_pc), .alloc_rob_id(alloc_rob_id), .full(full),
      .query_id1(query_id1), .query_id2(query_id2),
      .query_ready1(query_ready1), .query_ready2(query_ready2),
      .query_val1(query_val1), .query_val2(query_val2),
      .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_rob_id(commit_rob_id), .commit_store(commit_store),
      .rollback(rollback), .rollback_pc(rollback_pc)
   );

   task automatic idle_inputs();
      alloc_valid = 0; alloc_rd = 0; alloc_is_store = 0; alloc_pc = 0;
      query_id1 = 0; query_id2 = 0;
      wb_valid = 0; wb_rob_id = 0; wb_value = 0; wb_mispredict = 0; wb_target_pc = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
   endtask

   task automatic alloc_n(input int n, input int rd_base);
      for (int i = 0; i < n; i++) begin
         alloc_valid = 1;
         alloc_rd = 5'(rd_base + i);
         alloc_pc = 32'h1000 + 32'(4 * i);
         tick();
      end
      alloc_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b expected 0", commit_valid); end
      checks++; if (rollback !== 1'b0) begin errors++; $display("FAIL reset_rollback got %0b expected 0", rollback); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b expected 0", full); end
      checks++; if (alloc_rob_id !== 5'd1) begin errors++; $display("FAIL reset_alloc_id got %0d expected 1", alloc_rob_id); end
      checks++; if (commit_rob_id !== 5'd0 || rollback_pc !== 32'd0) begin errors++; $display("FAIL reset_outputs got id %0d pc %h expected 0 0", commit_rob_id, rollback_pc); end
   endtask

   task automatic test_in_order_commit();
      logic [31:0] exp_val [3];
      logic [4:0]  exp_id;
      exp_val[0] = 32'h11; exp_val[1] = 32'h22; exp_val[2] = 32'h33;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1; alloc_rd = 5'(i + 1); alloc_is_store = (i == 1);
         exp_id = 5'(i + 1);
         checks++; if (alloc_rob_id !== exp_id) begin errors++; $display("FAIL alloc_id got %0d expected %0d", alloc_rob_id, exp_id); end
         tick();
      end
      idle_inputs();
      checks++; if (dut.count_q !== 5'd3) begin errors++; $display("FAIL count_after_3 got %0d expected 3", dut.count_q); end
      wb_valid = 1; wb_rob_id = 3; wb_value = 32'h33; tick();
      wb_rob_id = 1; wb_value = 32'h11; tick();
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL no_wb_commit_bypass got %0b expected 0", commit_valid); end
      wb_rob_id = 2; wb_value = 32'h22; tick();
      wb_valid = 0;
      for (int k = 0; k < 3; k++) begin
         exp_id = 5'(k + 1);
         checks++;
         if (commit_valid !== 1'b1 || commit_rob_id !== exp_id || commit_rd !== exp_id ||
             commit_value !== exp_val[k] || commit_store !== (k == 1)) begin
            errors++;
            $display("FAIL in_order_commit%0d got v%0b id%0d rd%0d val %h st%0b expected v1 id%0d rd%0d val %h st%0b",
                     k, commit_valid, commit_rob_id, commit_rd, commit_value, commit_store,
                     exp_id, exp_id, exp_val[k], (k == 1));
         end
         tick();
      end
      checks++; if (commit_valid !== 1'b0 || dut.count_q !== 5'd0) begin errors++; $display("FAIL drained got v%0b count %0d expected 0 0", commit_valid, dut.count_q); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      alloc_n(16, 1);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after_16 got %0b expected 1", full); end
      alloc_valid = 1; alloc_rd = 5'd20; tick(); alloc_valid = 0;
      checks++; if (alloc_rob_id !== 5'd1 || dut.count_q !== 5'd16) begin errors++; $display("FAIL alloc17_ignored got id %0d count %0d expected 1 16", alloc_rob_id, dut.count_q); end
      wb_valid = 1; wb_rob_id = 1; wb_value = 32'h55; tick(); wb_valid = 0;
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL full_commit_early got %0b expected 0", commit_valid); end
      tick();
      checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 5'd1 || commit_value !== 32'h55 || full !== 1'b0) begin
         errors++; $display("FAIL full_commit got v%0b id%0d val %h full%0b expected v1 id1 val 55 full0", commit_valid, commit_rob_id, commit_value, full);
      end
      alloc_valid = 1; alloc_rd = 5'd7;
      checks++; if (alloc_rob_id !== 5'd1) begin errors++; $display("FAIL wrap_alloc_id got %0d expected 1", alloc_rob_id); end
      tick(); alloc_valid = 0;
      checks++; if (full !== 1'b1 || alloc_rob_id !== 5'd2) begin errors++; $display("FAIL wrap_refill got full%0b id%0d expected 1 2", full, alloc_rob_id); end
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc_n(3, 1);
      wb_valid = 1; wb_rob_id = 3; wb_value = 32'h33; tick();
      wb_rob_id = 1; wb_value = 32'h4; wb_mispredict = 1; wb_target_pc = 32'h100; tick();
      wb_valid = 0; wb_mispredict = 0; wb_target_pc = 0;
      alloc_valid = 1; alloc_rd = 5'd9; tick(); alloc_valid = 0;
      checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 5'd1 || commit_value !== 32'h4) begin
         errors++; $display("FAIL mispredict_commit got v%0b id%0d val %h expected v1 id1 val 4", commit_valid, commit_rob_id, commit_value);
      end
      checks++; if (rollback !== 1'b1 || rollback_pc !== 32'h100) begin errors++; $display("FAIL rollback got %0b pc %h expected 1 100", rollback, rollback_pc); end
      checks++; if (dut.count_q !== 5'd0 || alloc_rob_id !== 5'd1) begin errors++; $display("FAIL flush_state got count %0d id %0d expected 0 1", dut.count_q, alloc_rob_id); end
      tick();
      checks++; if (rollback !== 1'b0 || rollback_pc !== 32'd0) begin errors++; $display("FAIL rollback_pulse got %0b pc %h expected 0 0", rollback, rollback_pc); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL flushed_no_commit%0d got %0b expected 0", k, commit_valid); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      alloc_n(16, 1);
      wb_valid = 1; wb_rob_id = 1; wb_value = 32'h77; tick(); wb_valid = 0;
      alloc_valid = 1; alloc_rd = 5'd9;
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full_before got %0b expected 1", full); end
      tick();
      checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 5'd1 || full !== 1'b0 || alloc_rob_id !== 5'd1) begin
         errors++; $display("FAIL b2b_refused got v%0b id%0d full%0b tail_id%0d expected 1 1 0 1", commit_valid, commit_rob_id, full, alloc_rob_id);
      end
      tick(); alloc_valid = 0;
      checks++; if (full !== 1'b1 || alloc_rob_id !== 5'd2 || commit_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_accepted got full%0b id%0d v%0b expected 1 2 0", full, alloc_rob_id, commit_valid);
      end
   endtask

   task automatic test_query_bypass();
      do_reset();
      alloc_n(2, 1);
      query_id1 = 2; query_id2 = 0;
      wb_valid = 1; wb_rob_id = 2; wb_value = 32'hAB;
      #1;
      checks++; if (query_ready1 !== 1'b1 || query_val1 !== 32'hAB) begin errors++; $display("FAIL query_bypass got r%0b val %h expected 1 ab", query_ready1, query_val1); end
      checks++; if (query_ready2 !== 1'b1 || query_val2 !== 32'h0) begin errors++; $display("FAIL query_zero got r%0b val %h expected 1 0", query_ready2, query_val2); end
      query_id2 = 1;
      #1;
      checks++; if (query_ready2 !== 1'b0) begin errors++; $display("FAIL query_not_ready got %0b expected 0", query_ready2); end
      tick(); wb_valid = 0; wb_value = 0;
      #1;
      checks++; if (query_ready1 !== 1'b1 || query_val1 !== 32'hAB) begin errors++; $display("FAIL query_stored got r%0b val %h expected 1 ab", query_ready1, query_val1); end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      alloc_n(5, 1);
      wb_valid = 1; wb_rob_id = 1; wb_value = 32'h99; tick(); wb_valid = 0;
      tick();
      checks++; if (commit_valid !== 1'b1 || commit_value !== 32'h99) begin errors++; $display("FAIL pre_reset_commit got v%0b val %h expected 1 99", commit_valid, commit_value); end
      #2 rst_n = 0;
      #1;
      checks++; if (commit_valid !== 1'b0 || commit_rob_id !== 5'd0 || commit_value !== 32'd0) begin
         errors++; $display("FAIL async_reset_outputs got v%0b id%0d val %h expected 0 0 0", commit_valid, commit_rob_id, commit_value);
      end
      @(negedge clk); rst_n = 1; #1;
      checks++; if (dut.count_q !== 5'd0 || alloc_rob_id !== 5'd1 || full !== 1'b0) begin
         errors++; $display("FAIL after_reset got count %0d id %0d full %0b expected 0 1 0", dut.count_q, alloc_rob_id, full);
      end
      alloc_valid = 1; alloc_rd = 5'd4; tick(); alloc_valid = 0;
      checks++; if (alloc_rob_id !== 5'd2 || commit_valid !== 1'b0) begin errors++; $display("FAIL first_alloc_after_reset got next id %0d v%0b expected 2 0", alloc_rob_id, commit_valid); end
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      test_reset();
      test_in_order_commit();
      test_full_wrap();
      test_mispredict();
      test_back_to_back();
      test_query_bypass();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
